// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with an occupancy counter; shared by the UART RX and TX paths.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 serial receiver: synchronizer, bit-timing FSM and a byte FIFO on a valid/ready stream.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 27,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rxd,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            frame_err,
  output logic                            overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  rx_state_e                 state;
  rx_state_e                 state_nxt;
  logic                      sync1;
  logic                      rxs;
  logic [CW-1:0]             bcnt;
  logic [IW-1:0]             bidx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      bcnt_clr;
  logic                      bidx_clr;
  logic                      bit_take;
  logic                      byte_done;
  logic                      stop_bad;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bcnt      <= bcnt_clr ? '0 : bcnt + 1'b1;
      frame_err <= stop_bad;
      overrun   <= byte_done && fifo_full && !(rx_ready && !fifo_empty);
      if (bidx_clr)      bidx <= '0;
      else if (bit_take) bidx <= bidx + 1'b1;
      if (bit_take) shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
    end
  end

  // Start is checked at mid-bit; every later sample lands a full bit period on.
  always_comb begin
    state_nxt = state;
    bcnt_clr  = 1'b0;
    bidx_clr  = 1'b0;
    bit_take  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          bcnt_clr  = 1'b1;
        end
      end
      START: begin
        if (bcnt == HALF_M1) begin
          if (!rxs) begin
            state_nxt = DATA;
            bcnt_clr  = 1'b1;
            bidx_clr  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (bcnt == FULL_M1) begin
          bit_take = 1'b1;
          bcnt_clr = 1'b1;
          if (bidx == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (bcnt == FULL_M1) begin
          if (rxs) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_done),
    .din   (shreg),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench for uart_rx_capture at 8 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_capture;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  // Cycles from driving the start edge to the cycle just before the stop sample.
  localparam int READY_DLY = 2 + CPB / 2 + 9 * CPB;

  logic          clk;
  logic          rst;
  logic          rxd;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] level;
  logic          frame_err;
  logic          overrun;

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx_capture #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .level     (level),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after rising edges, so the falling edge sees what the next rising edge will use.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (stop_low_bits > 0) begin
      rxd = 1'b0;
      repeat (CPB * stop_low_bits) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 4000 && got_q.size() < n; i++) @(posedge clk);
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (level !== '0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_single_frame();
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    logic [7:0] e;
    logic [7:0] g;
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 0);
    wait_rx(1);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL single_data got=%h exp=%h", g, e); end
    end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL single_frame_err got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (ovr_cnt - o0 !== 0) begin failures++; $display("[TB] FAIL single_overrun got=%0d exp=0", ovr_cnt - o0); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_false_start();
    int f0 = ferr_cnt;
    rx_ready = 1'b1;
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    @(negedge clk);
    checks++; if (got_q.size() !== 0) begin failures++; $display("[TB] FAIL false_start_bytes got=%0d exp=0", got_q.size()); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL false_start_valid got=%b exp=0", rx_valid); end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL false_start_frame_err got=%0d exp=0", ferr_cnt - f0); end
    got_q.delete();
  endtask

  task automatic test_frame_error();
    int f0 = ferr_cnt;
    logic [7:0] e;
    logic [7:0] g;
    rx_ready = 1'b1;
    send_frame(8'h3C, 20);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0);
    wait_rx(1);
    checks++; if (ferr_cnt - f0 !== 1) begin failures++; $display("[TB] FAIL break_frame_err got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL break_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL break_data got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    int o0 = ovr_cnt;
    logic [7:0] e;
    logic [7:0] g;
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 0);
    end
    @(negedge clk);
    checks++; if (level !== LW'(DEPTH)) begin failures++; $display("[TB] FAIL overrun_level got=%0d exp=%0d", level, DEPTH); end
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("[TB] FAIL overrun_pulses got=%0d exp=1", ovr_cnt - o0); end
    @(posedge clk); #1 rx_ready = 1'b1;
    wait_rx(DEPTH);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL overrun_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL overrun_data got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_full_pop_same_cycle();
    int o0;
    logic [7:0] e;
    logic [7:0] g;
    rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      send_frame(8'h21 + 8'(i), 0);
    end
    @(negedge clk);
    checks++; if (level !== LW'(DEPTH)) begin failures++; $display("[TB] FAIL full_level_before got=%0d exp=%0d", level, DEPTH); end
    o0 = ovr_cnt;
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 0);
      begin
        @(posedge clk);
        repeat (READY_DLY) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        checks++; if (level !== LW'(DEPTH)) begin failures++; $display("[TB] FAIL full_level_pushpop got=%0d exp=%0d", level, DEPTH); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL full_overrun got=%b exp=0", overrun); end
      end
    join
    checks++; if (ovr_cnt - o0 !== 0) begin failures++; $display("[TB] FAIL full_overrun_pulses got=%0d exp=0", ovr_cnt - o0); end
    rx_ready = 1'b1;
    wait_rx(DEPTH + 1);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL full_data got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int f0 = ferr_cnt;
    logic [7:0] part = 8'hF0;
    logic [7:0] e;
    logic [7:0] g;
    rx_ready = 1'b0;
    send_frame(8'h5A, 0);
    @(negedge clk);
    checks++; if (level !== LW'(1)) begin failures++; $display("[TB] FAIL midrst_level_before got=%0d exp=1", level); end
    @(posedge clk); #1 rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      rxd = part[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data got=%h exp=00", rx_data); end
    checks++; if (level !== '0) begin failures++; $display("[TB] FAIL midrst_level got=%0d exp=0", level); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pulses got=%b%b exp=00", frame_err, overrun); end
    rx_ready = 1'b1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 0);
    wait_rx(1);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("[TB] FAIL midrst_rx_data got=%h exp=%h", g, e); end
    end
    checks++; if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL midrst_frame_err got=%0d exp=0", ferr_cnt - f0); end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_full_pop_same_cycle();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
